lcd1602_write_sequencer: RTL and testbench

//  Sequences byte writes to an HD44780-compatible 16x2 character LCD. Accepts

---
 rtl/lcd1602_write_sequencer_if.sv | 29 ++
 rtl/lcd1602_write_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_lcd1602_write_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd1602_write_sequencer_if.sv
// ----------------------------------------------------------------------------
// lcd1602_write_sequencer_if
//   Byte-write request channel into the LCD write sequencer.
//   req_valid : requester has a byte to write
//   req_ready : sequencer accepts a byte this cycle
//   req_rs    : 0 = command, 1 = character data
//   req_data  : byte to write
//   Modports: master (requester side), slave (sequencer side).
// ----------------------------------------------------------------------------
interface lcd1602_write_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;

    modport master (
        output req_valid,
        output req_rs,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rs,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/lcd1602_write_sequencer.sv
// ----------------------------------------------------------------------------
// lcd1602_write_sequencer
//   Turns accepted command/data bytes into the HD44780 rs/data/en waveform
//   with programmable setup, enable-pulse and execution delays.
//   Optional feature macro: LCD_AUTO_INIT_EN -- when defined, the block waits
//   T_PWRUP cycles after reset and issues 0x38, 0x0C, 0x06, 0x01 itself.
// Ports
//   i_clk       : system clock
//   i_rst       : synchronous reset, active-high
//   io_req      : request channel (slave side): valid/ready/rs/data
//   o_busy      : transfer or init in progress (= ~req_ready)
//   o_init_done : init complete, sticky until reset
//   o_lcd_rs    : LCD register select
//   o_lcd_rw    : LCD read/write, always 0
//   o_lcd_en    : LCD enable strobe
//   o_lcd_data  : LCD data bus
// ----------------------------------------------------------------------------
module lcd1602_write_sequencer #(
    parameter int unsigned T_SETUP   = 4,
    parameter int unsigned T_EN_HIGH = 25,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_CLR     = 82000,
    parameter int unsigned T_PWRUP   = 750000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    lcd1602_write_sequencer_if.slave      io_req,
    output logic                          o_busy,
    output logic                          o_init_done,
    output logic                          o_lcd_rs,
    output logic                          o_lcd_rw,
    output logic                          o_lcd_en,
    output logic [7:0]                    o_lcd_data
);

    // Counter is sized for the longest delay, never narrower than 20 bits.
    localparam int unsigned MaxA = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int unsigned MaxB = (T_CMD > T_CLR) ? T_CMD : T_CLR;
    localparam int unsigned MaxC = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned MaxT = (MaxC > T_PWRUP) ? MaxC : T_PWRUP;
    localparam int unsigned CntW = ($clog2(MaxT + 1) > 20) ? $clog2(MaxT + 1) : 20;

    // Reload values are delay-1 so a state lasts exactly "delay" cycles; 0 acts as 1.
    localparam logic [CntW-1:0] LdSetup = CntW'((T_SETUP == 0) ? 0 : T_SETUP - 1);
    localparam logic [CntW-1:0] LdEnHi  = CntW'((T_EN_HIGH == 0) ? 0 : T_EN_HIGH - 1);
    localparam logic [CntW-1:0] LdCmd   = CntW'((T_CMD == 0) ? 0 : T_CMD - 1);
    localparam logic [CntW-1:0] LdClr   = CntW'((T_CLR == 0) ? 0 : T_CLR - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

`ifdef LCD_AUTO_INIT_EN
    localparam logic [CntW-1:0] LdPwrup = CntW'((T_PWRUP == 0) ? 0 : T_PWRUP - 1);

    typedef enum logic [2:0] {StPwrup, StInitLoad, StIdle, StSetup, StEnHi, StWait} state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    return 8'h0C;   // display on, cursor off
            2'd2:    return 8'h06;   // entry mode: increment, no shift
            default: return 8'h01;   // clear display
        endcase
    endfunction

    logic [1:0] r_init_idx;
`else
    typedef enum logic [1:0] {StIdle, StSetup, StEnHi, StWait} state_t;
`endif

    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_req_ready;
    logic            r_busy;
    logic            r_init_done;
    logic            r_lcd_rs;
    logic            r_lcd_en;
    logic [7:0]      r_lcd_data;
    logic            w_is_clr;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign w_is_clr = ~r_lcd_rs && (r_lcd_data[7:2] == 6'd0) && (r_lcd_data[1:0] != 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lcd_en    <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_data  <= 8'h00;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
`ifdef LCD_AUTO_INIT_EN
            r_state     <= StPwrup;
            r_cnt       <= LdPwrup;
            r_init_idx  <= 2'd0;
`else
            r_state     <= StIdle;
            r_cnt       <= '0;
`endif
        end else begin
            case (r_state)
`ifdef LCD_AUTO_INIT_EN
                StPwrup: begin
                    if (r_cnt == '0) r_state <= StInitLoad;
                    else             r_cnt   <= r_cnt - CntOne;
                end
                // Plays the role of the handshake cycle for the built-in commands.
                StInitLoad: begin
                    r_lcd_rs   <= 1'b0;
                    r_lcd_data <= init_cmd(r_init_idx);
                    r_init_idx <= r_init_idx + 2'd1;
                    r_cnt      <= LdSetup;
                    r_state    <= StSetup;
                end
`endif
                StIdle: begin
                    if (r_req_ready && io_req.req_valid) begin
                        r_lcd_rs    <= io_req.req_rs;
                        r_lcd_data  <= io_req.req_data;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cnt       <= LdSetup;
                        r_state     <= StSetup;
                    end else begin
                        // Only reached with ready low on the first cycle out of reset.
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_init_done <= 1'b1;
                    end
                end
                StSetup: begin
                    if (r_cnt == '0) begin
                        r_lcd_en <= 1'b1;
                        r_cnt    <= LdEnHi;
                        r_state  <= StEnHi;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end
                StEnHi: begin
                    if (r_cnt == '0) begin
                        r_lcd_en <= 1'b0;
                        r_cnt    <= w_is_clr ? LdClr : LdCmd;
                        r_state  <= StWait;
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end
                StWait: begin
                    if (r_cnt == '0) begin
`ifdef LCD_AUTO_INIT_EN
                        // Index wraps to 0 once the last init command has been loaded.
                        if (!r_init_done && (r_init_idx != 2'd0)) begin
                            r_state <= StInitLoad;
                        end else begin
                            r_state     <= StIdle;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_init_done <= 1'b1;
                        end
`else
                        r_state     <= StIdle;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_init_done <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt - CntOne;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_req.req_ready = r_req_ready;
    assign o_busy           = r_busy;
    assign o_init_done      = r_init_done;
    assign o_lcd_rs         = r_lcd_rs;
    assign o_lcd_rw         = 1'b0;
    assign o_lcd_en         = r_lcd_en;
    assign o_lcd_data       = r_lcd_data;

endmodule

// File: tb/tb_lcd1602_write_sequencer.sv
// ----------------------------------------------------------------------------
// tb_lcd1602_write_sequencer
//   Randomized bench for the LCD write sequencer. A driver issues requests
//   and pushes the expected transfer into a scoreboard queue; a monitor
//   watches the LCD pins and req_ready and checks each strobe against it.
// ----------------------------------------------------------------------------
module tb_lcd1602_write_sequencer;
    localparam int unsigned TS = 2;
    localparam int unsigned TE = 3;
    localparam int unsigned TC = 5;
    localparam int unsigned TL = 9;
    localparam int unsigned TP = 10;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    lcd1602_write_sequencer_if u_if ();

    lcd1602_write_sequencer #(
        .T_SETUP   (TS),
        .T_EN_HIGH (TE),
        .T_CMD     (TC),
        .T_CLR     (TL),
        .T_PWRUP   (TP)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .io_req      (u_if),
        .o_busy      (busy),
        .o_init_done (init_done),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_en    (lcd_en),
        .o_lcd_data  (lcd_data)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         n;          // handshake (or init load) cycle
        bit         chk_ready;  // req_ready expected to rise after this one
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   have_cur = 0;
    bit   prev_en = 0;
    bit   prev_ready = 0;
    int   rise_cyc = 0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Execution wait from the LCD rules: clear/home commands are slow.
    function automatic int wait_len(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'd1 && d <= 8'd3) ? TL : TC;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                have_cur   = 0;
                prev_en    = 0;
                prev_ready = 0;
            end else begin
                if (lcd_en && !prev_en) begin
                    if (have_cur && cur.chk_ready) chk("ready_before_next_pulse", 0, 1);
                    if (sb.size() == 0) begin
                        chk("unexpected_en_pulse", 1, 0);
                        have_cur = 0;
                    end else begin
                        cur      = sb.pop_front();
                        have_cur = 1;
                        rise_cyc = cyc;
                        chk("en_rise_cycle", cyc, cur.n + 1 + TS);
                        chk("rs_at_rise", int'(lcd_rs), int'(cur.rs));
                        chk("data_at_rise", int'(lcd_data), int'(cur.data));
                        chk("rw_low", int'(lcd_rw), 0);
                        chk("busy_during_xfer", int'(busy), 1);
                    end
                end
                if (!lcd_en && prev_en && have_cur) begin
                    chk("en_width", cyc - rise_cyc, TE);
                    chk("data_hold_at_fall", int'({lcd_rs, lcd_data}), int'({cur.rs, cur.data}));
                end
                if (u_if.req_ready && !prev_ready && have_cur) begin
                    if (!cur.chk_ready) begin
                        chk("ready_rose_mid_init", 1, 0);
                    end else begin
                        chk("ready_rise_cycle", cyc,
                            cur.n + 1 + TS + TE + wait_len(cur.rs, cur.data));
                        chk("busy_low_when_ready", int'(busy), 0);
                        chk("init_done_when_ready", int'(init_done), 1);
                        chk("data_hold_in_wait", int'(lcd_data), int'(cur.data));
                    end
                    have_cur = 0;
                end
                prev_en    = lcd_en;
                prev_ready = u_if.req_ready;
            end
        end
    end

    // All driver tasks start and end at posedge + #1.
    task automatic send_one(input logic rs, input logic [7:0] data, input bit hold);
        exp_t e;
        int   bound;
        bound = 0;
        while (!u_if.req_ready) begin
            if (!hold) begin
                u_if.req_valid = 1'($urandom);
                u_if.req_rs    = 1'($urandom);
                u_if.req_data  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            bound++;
            if (bound > 100) begin
                chk("ready_timeout", 0, 1);
                return;
            end
        end
        u_if.req_valid = 1'b1;
        u_if.req_rs    = rs;
        u_if.req_data  = data;
        e.rs        = rs;
        e.data      = data;
        e.n         = cyc;
        e.chk_ready = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) u_if.req_valid = 1'b0;
    endtask

    task automatic run_traffic(input int n, input bit hold);
        logic       rs;
        logic [7:0] data;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: begin rs = 1'b0; data = 8'($urandom_range(1, 3)); end
                1: begin rs = 1'b0; data = 8'($urandom); end
                default: begin rs = 1'b1; data = 8'($urandom); end
            endcase
            if (!hold && u_if.req_ready && $urandom_range(0, 2) == 0) begin
                u_if.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_one(rs, data, hold);
        end
        u_if.req_valid = 1'b0;
    endtask

    task automatic drain();
        int bound;
        bound = 0;
        u_if.req_valid = 1'b0;
        while (sb.size() != 0 || have_cur || !u_if.req_ready) begin
            @(posedge clk);
            #1;
            bound++;
            if (bound > 2000) begin
                chk("drain_timeout", 0, 1);
                return;
            end
        end
        chk("scoreboard_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        int k;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("rst_en", int'(lcd_en), 0);
        chk("rst_ready", int'(u_if.req_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_init_done", int'(init_done), 0);
        chk("rst_rs", int'(lcd_rs), 0);
        chk("rst_data", int'(lcd_data), 0);
        chk("rst_rw", int'(lcd_rw), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        k   = cyc;
`ifdef LCD_AUTO_INIT_EN
        begin
            logic [7:0] init_seq [4];
            int         n;
            int         bound;
            init_seq = '{8'h38, 8'h0C, 8'h06, 8'h01};
            n = k + TP;
            for (int i = 0; i < 4; i++) begin
                exp_t e;
                e.rs        = 1'b0;
                e.data      = init_seq[i];
                e.n         = n;
                e.chk_ready = (i == 3);
                sb.push_back(e);
                n += 1 + TS + TE + wait_len(1'b0, init_seq[i]);
            end
            // A pending request held throughout init must not be taken early.
            u_if.req_valid = 1'b1;
            u_if.req_rs    = 1'b1;
            u_if.req_data  = 8'hA5;
            bound = 0;
            while (!u_if.req_ready) begin
                @(posedge clk);
                #1;
                bound++;
                if (bound > 500) begin
                    chk("init_timeout", 0, 1);
                    break;
                end
            end
            u_if.req_valid = 1'b0;
            chk("init_ready_cycle", cyc, n);
            chk("init_done_after_init", int'(init_done), 1);
        end
`else
        chk("ready_low_release_cycle", int'(u_if.req_ready), 0);
        @(posedge clk);
        #1;
        chk("ready_after_release", int'(u_if.req_ready), 1);
        chk("init_done_after_release", int'(init_done), 1);
        chk("busy_after_release", int'(busy), 0);
`endif
    endtask

    initial begin
        int bound;
        rst            = 1'b1;
        u_if.req_valid = 1'b0;
        u_if.req_rs    = 1'b0;
        u_if.req_data  = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        // Directed: plain data, then clear/home/display commands.
        send_one(1'b1, 8'h57, 1'b0);
        send_one(1'b0, 8'h01, 1'b0);
        send_one(1'b0, 8'h0C, 1'b0);
        send_one(1'b0, 8'h02, 1'b0);
        send_one(1'b0, 8'h03, 1'b0);
        send_one(1'b1, 8'h01, 1'b0);
        drain();

        // Random traffic with valid/data scrambled while busy.
        run_traffic(16, 1'b0);
        drain();

        // valid held high across three back-to-back bytes.
        run_traffic(3, 1'b1);
        drain();

        // Reset while the enable strobe is high.
        send_one(1'b1, 8'h41, 1'b0);
        bound = 0;
        while (!lcd_en) begin
            @(posedge clk);
            #1;
            bound++;
            if (bound > 50) begin
                chk("en_wait_timeout", 0, 1);
                break;
            end
        end
        do_reset();

        run_traffic(6, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
